// File: rtl/md_pkg.sv
// Shared types and constants for the metadata broadcaster.
package md_pkg;

  localparam int unsigned DW_DEFAULT = 512;
  localparam int unsigned MAX_N_OUT  = 8;

  typedef logic [DW_DEFAULT-1:0] md_beat_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/md_bcast_fifo.sv
// Per-lane FIFO with registered full/empty flags; storage is not reset.
module md_bcast_fifo
  import md_pkg::*;
#(
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  localparam int unsigned PW = ptr_w(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          push_ok, pop;

  assign push_ok = push_i && !full_q;
  assign pop     = !empty_q && ready_i;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = full_q;
  assign valid_o = !empty_q;
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/md_broadcaster.sv
// 1-to-N metadata broadcaster: per-lane FIFOs, masked replication, drop counter.
module md_broadcaster
  import md_pkg::*;
#(
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [DW-1:0]       AXIS_IN_MD_TDATA,
  input  logic                AXIS_IN_MD_TVALID,
  output logic                AXIS_IN_MD_TREADY,
  input  logic [N_OUT-1:0]    CFG_EN_MASK,
  output logic [N_OUT*DW-1:0] AXIS_OUT_MD_TDATA,
  output logic [N_OUT-1:0]    AXIS_OUT_MD_TVALID,
  input  logic [N_OUT-1:0]    AXIS_OUT_MD_TREADY,
  output logic [CNT_W-1:0]    DROP_CNT
);

  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] push;
  logic             ready_en_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             accept;

  // Ready is held low through reset and released on the first edge after it.
  assign AXIS_IN_MD_TREADY = ready_en_q && (&(~(CFG_EN_MASK & full)));
  assign accept            = AXIS_IN_MD_TVALID && AXIS_IN_MD_TREADY;
  assign push              = {N_OUT{accept}} & CFG_EN_MASK;

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    md_bcast_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .push_i  (push[i]),
      .data_i  (AXIS_IN_MD_TDATA),
      .full_o  (full[i]),
      .valid_o (AXIS_OUT_MD_TVALID[i]),
      .ready_i (AXIS_OUT_MD_TREADY[i]),
      .data_o  (AXIS_OUT_MD_TDATA[i*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept && (CFG_EN_MASK == '0)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_md_broadcaster.sv
// Randomised and directed bench for md_broadcaster against a queue-based model.
module tb_md_broadcaster;

  localparam int unsigned DW    = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic              clk;
  logic              resetn;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      mask;
  logic [N*DW-1:0]   out_data;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [CNT_W-1:0]  drop_cnt;

  md_broadcaster #(
    .DW         (DW),
    .N_OUT      (N),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .AXIS_IN_MD_TDATA   (in_data),
    .AXIS_IN_MD_TVALID  (in_valid),
    .AXIS_IN_MD_TREADY  (in_ready),
    .CFG_EN_MASK        (mask),
    .AXIS_OUT_MD_TDATA  (out_data),
    .AXIS_OUT_MD_TVALID (out_valid),
    .AXIS_OUT_MD_TREADY (out_ready),
    .DROP_CNT           (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per lane, drop total, and post-reset ready gate.
  logic [DW-1:0] mq [N][$];
  int            m_drops;
  bit            m_ready_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_rdy;
    exp_rdy = m_ready_en;
    for (int i = 0; i < N; i++)
      if (mask[i] && mq[i].size() >= DEPTH) exp_rdy = 1'b0;
    check("in_tready", 64'(in_ready), 64'(exp_rdy));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops % (1 << CNT_W)));
    for (int i = 0; i < N; i++) begin
      check($sformatf("tvalid%0d", i), 64'(out_valid[i]), 64'(mq[i].size() > 0));
      if (mq[i].size() > 0)
        check($sformatf("tdata%0d", i), 64'(out_data[i*DW +: DW]), 64'(mq[i][0]));
    end
  endtask

  // One cycle: drive, check before the edge, then advance the model across the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [N-1:0] m,
                      input logic [N-1:0] r);
    bit          acc;
    bit [N-1:0]  pop;
    in_valid  = v;
    in_data   = d;
    mask      = m;
    out_ready = r;
    #1;
    check_outputs();
    acc = v && m_ready_en;
    for (int i = 0; i < N; i++)
      if (m[i] && mq[i].size() >= DEPTH) acc = 1'b0;
    for (int i = 0; i < N; i++) pop[i] = (mq[i].size() > 0) && r[i];
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (pop[i]) void'(mq[i].pop_front());
      if (acc && m[i]) mq[i].push_back(d);
    end
    if (acc && m == '0) m_drops++;
    m_ready_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mq[i].delete();
    m_drops    = 0;
    m_ready_en = 1'b0;
    check("rst_tready", 64'(in_ready), 64'(0));
    check("rst_tvalid", 64'(out_valid), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk);
    #1;
    check("rst_hold_tready", 64'(in_ready), 64'(0));
    check("rst_hold_tvalid", 64'(out_valid), 64'(0));
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    logic [N-1:0] m;
    logic [N-1:0] r;
    in_valid  = 1'b0;
    in_data   = '0;
    mask      = '0;
    out_ready = '0;
    resetn    = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    step(1'b0, '0, 4'b0011, 4'b1111);
    check("ready_after_rst", 64'(in_ready), 64'(1));

    // Broadcast to lanes 0/1 back-to-back.
    step(1'b1, 16'h1, 4'b0011, 4'b1111);
    step(1'b1, 16'h2, 4'b0011, 4'b1111);
    step(1'b1, 16'h3, 4'b0011, 4'b1111);
    step(1'b0, '0, 4'b0011, 4'b1111);
    step(1'b0, '0, 4'b0011, 4'b1111);
    step(1'b0, '0, 4'b0011, 4'b1111);

    // Lane 1 stalled: two accepts then backpressure; then drain.
    step(1'b1, 16'h1, 4'b0011, 4'b1101);
    step(1'b1, 16'h2, 4'b0011, 4'b1101);
    step(1'b1, 16'h3, 4'b0011, 4'b1101);
    step(1'b1, 16'h3, 4'b0011, 4'b1101);
    check("stall_lane1_depth", 64'(mq[1].size()), 64'(DEPTH));
    // Disabled full lane must not block.
    step(1'b1, 16'h7, 4'b0001, 4'b1101);
    check("dis_lane_ready", 64'(in_ready), 64'(1));
    step(1'b1, 16'h8, 4'b0001, 4'b1101);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 4'b0011, 4'b1111);

    // Mask routing.
    step(1'b1, 16'hA, 4'b0101, 4'b1111);
    step(1'b1, 16'hB, 4'b1010, 4'b1111);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 4'b0000, 4'b1111);

    // Drops: 5 then wrap at 17.
    for (int k = 0; k < 5; k++) step(1'b1, 16'(k), 4'b0000, 4'b1111);
    step(1'b0, '0, 4'b0000, 4'b1111);
    check("drop5", 64'(drop_cnt), 64'(5));
    for (int k = 0; k < 12; k++) step(1'b1, 16'(k), 4'b0000, 4'b1111);
    step(1'b0, '0, 4'b0000, 4'b1111);
    check("drop17_wrap", 64'(drop_cnt), 64'(1));

    // Reset mid-stream with two beats queued on lane 0.
    step(1'b1, 16'h11, 4'b0001, 4'b0000);
    step(1'b1, 16'h22, 4'b0001, 4'b0000);
    check("queued_lane0", 64'(out_valid[0]), 64'(1));
    do_reset();
    step(1'b1, 16'h33, 4'b0001, 4'b1111);
    step(1'b0, '0, 4'b0001, 4'b1111);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      m = N'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      r = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      step($urandom_range(0, 3) != 0, 16'($urandom), m, r);
    end
    for (int k = 0; k < 6; k++) step(1'b0, '0, 4'b0000, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
